rv32_multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the immediate generator select, ALU operand muxes, PC/IR/register-file write enables and the shared instruction/data memory handshake.
- Sits between the instruction register and the datapath; it contains no datapath arithmetic.

---
 rtl/rv32_multicycle_ctrl.sv | 133 +++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl: multi-cycle RV32I main control FSM (fetch/decode/exec/mem/wb sequencing)
module rv32_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [2:0]  imm_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);
    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [3:0] {C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC} cls_t;
    state_t state, state_n;
    cls_t cls, dec_cls;
    logic [2:0] dec_imm;
    logic [CW-1:0] cnt;
    logic waiting, tmo;
    logic unused;
    assign unused = ^instr[31:12];
    always_comb begin
        case (instr[6:0])
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BR;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            default:    dec_cls = C_NONE;
        endcase
    end
    assign dec_imm = (dec_cls == C_I || dec_cls == C_LOAD || dec_cls == C_JALR) ? 3'd0 :
                     dec_cls == C_STORE ? 3'd1 :
                     dec_cls == C_BR ? 3'd2 :
                     dec_cls == C_JAL ? 3'd3 :
                     (dec_cls == C_LUI || dec_cls == C_AUIPC) ? 3'd4 : 3'd0;
    // mem_ready in the last allowed cycle takes priority over the timeout
    assign waiting = (state == FETCH || state == MEM) && !mem_ready;
    assign tmo = waiting && (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT - 1));
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = FETCH;
            FETCH:   state_n = mem_ready ? DECODE : tmo ? TRAP : FETCH;
            DECODE:  state_n = (dec_cls == C_NONE) ? TRAP : EXEC;
            EXEC:    state_n = (cls == C_LOAD || cls == C_STORE) ? MEM : (cls == C_BR) ? FETCH : WB;
            MEM:     state_n = mem_ready ? ((cls == C_LOAD) ? WB : FETCH) : tmo ? TRAP : MEM;
            WB:      state_n = FETCH;
            default: state_n = TRAP;
        endcase
    end
    always_comb begin
        ir_we = 1'b0;
        pc_we = 1'b0;
        pc_sel = 2'd0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op = 2'd0;
        reg_we = 1'b0;
        wb_sel = 2'd0;
        retire = 1'b0;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                ir_we = mem_ready;
            end
            EXEC: begin
                alu_src_b = cls != C_R && cls != C_BR;
                alu_src_a = cls == C_AUIPC;
                alu_op = (cls == C_R || cls == C_I) ? 2'd2 : (cls == C_BR) ? 2'd1 : 2'd0;
                pc_we = cls == C_BR;
                pc_sel = (cls == C_BR) ? {1'b0, branch_taken} : 2'd0;
                retire = cls == C_BR;
            end
            MEM: begin
                mem_req = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we = cls == C_STORE;
                pc_we = cls == C_STORE && mem_ready;
                retire = cls == C_STORE && mem_ready;
            end
            WB: begin
                reg_we = instr[11:7] != 5'd0;
                wb_sel = (cls == C_LOAD) ? 2'd1 : (cls == C_JAL || cls == C_JALR) ? 2'd2 :
                         (cls == C_LUI) ? 2'd3 : 2'd0;
                pc_we = 1'b1;
                pc_sel = (cls == C_JAL) ? 2'd1 : (cls == C_JALR) ? 2'd2 : 2'd0;
                retire = 1'b1;
            end
            default: ;
        endcase
    end
    assign trap = state == TRAP;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cls <= C_NONE;
            imm_sel <= 3'd0;
            cnt <= '0;
            trap_cause <= 2'd0;
        end else begin
            state <= state_n;
            cnt <= waiting ? cnt + 1'b1 : '0;
            if (state == DECODE) begin
                cls <= dec_cls;
                imm_sel <= dec_imm;
            end
            if (state_n == TRAP && state != TRAP)
                trap_cause <= (state == DECODE) ? 2'd1 : 2'd2;
        end
    end
endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb_rv32_multicycle_ctrl: directed + random instruction traces checked against a per-phase reference model
module tb_rv32_multicycle_ctrl;
    localparam int TMO = 4;
    typedef struct packed {
        logic [2:0] imm_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       retire;
        logic       trap;
        logic [1:0] trap_cause;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0, branch_taken = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [2:0] imm_sel;
    logic ir_we, pc_we, mem_req, mem_we, mem_addr_sel, alu_src_a, alu_src_b, reg_we, retire, trap;
    logic [1:0] pc_sel, alu_op, wb_sel, trap_cause;
    vec_t obs;
    int vectors = 0, miscompares = 0;
    logic [2:0] cur_imm = 3'd0;

    rv32_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .imm_sel(imm_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire), .trap(trap),
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;
    assign obs = {imm_sel, ir_we, pc_we, pc_sel, mem_req, mem_we, mem_addr_sel, alu_src_a,
                  alu_src_b, alu_op, reg_we, wb_sel, retire, trap, trap_cause};

    task automatic check(input string tag, input vec_t e, input bit ci);
        vectors++;
        if (ci)
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        else
            assert (obs[17:0] === e[17:0]) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h (imm_sel ignored)", tag, obs, e);
            end
    endtask

    // entered at a falling edge; checks that cycle, returns at the next falling edge
    task automatic step(input string tag, input logic rdy, input logic bt, input vec_t e, input bit ci);
        mem_ready = rdy;
        branch_taken = bt;
        #1;
        check(tag, e, ci);
        @(negedge clk);
    endtask

    function automatic vec_t base();
        vec_t e;
        e = '0;
        e.imm_sel = cur_imm;
        return e;
    endfunction

    task automatic trap_steps(input logic [1:0] cause, input int n);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            e = base();
            e.trap = 1'b1;
            e.trap_cause = cause;
            step("trap", $urandom_range(0, 1) == 1, 1'b0, e, cause == 2'd2);
        end
    endtask

    task automatic do_reset(input int dly);
        #dly;
        rst = 1'b1;
        #1;
        cur_imm = 3'd0;
        check("reset", vec_t'(0), 1'b1);
        @(negedge clk);
        rst = 1'b0;
        step("idle", 1'b0, 1'b0, base(), 1'b1);
    endtask

    // expected trace of one instruction, from the first FETCH cycle to its retire (or trap)
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic bt);
        vec_t e;
        logic [6:0] op;
        bit r, ia, ld, st, br, jal, jalr, lui, aui;
        logic [2:0] imm;
        op = ins[6:0];
        r = op == 7'h33; ia = op == 7'h13; ld = op == 7'h03; st = op == 7'h23; br = op == 7'h63;
        jal = op == 7'h6f; jalr = op == 7'h67; lui = op == 7'h37; aui = op == 7'h17;
        imm = (ia || ld || jalr) ? 3'd0 : st ? 3'd1 : br ? 3'd2 : jal ? 3'd3 : (lui || aui) ? 3'd4 : 3'd0;
        instr = ins;
        for (int i = 0; i < fw && i < TMO; i++) begin
            e = base(); e.mem_req = 1'b1;
            step("fetch_wait", 1'b0, bt, e, 1'b1);
        end
        if (fw >= TMO) begin
            trap_steps(2'd2, 6);
            return;
        end
        e = base(); e.mem_req = 1'b1; e.ir_we = 1'b1;
        step("fetch", 1'b1, bt, e, 1'b1);
        step("decode", 1'b0, bt, base(), 1'b1);
        if (!(r || ia || ld || st || br || jal || jalr || lui || aui)) begin
            trap_steps(2'd1, 20);
            return;
        end
        cur_imm = imm;
        e = base();
        e.alu_src_b = !(r || br);
        e.alu_src_a = aui;
        e.alu_op = (r || ia) ? 2'd2 : br ? 2'd1 : 2'd0;
        if (br) begin
            e.pc_we = 1'b1; e.pc_sel = bt ? 2'd1 : 2'd0; e.retire = 1'b1;
        end
        step("exec", 1'b0, bt, e, 1'b1);
        if (br) return;
        if (ld || st) begin
            for (int i = 0; i < mw && i < TMO; i++) begin
                e = base(); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = st;
                step("mem_wait", 1'b0, bt, e, 1'b1);
            end
            if (mw >= TMO) begin
                trap_steps(2'd2, 6);
                return;
            end
            e = base(); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = st;
            e.pc_we = st; e.retire = st;
            step("mem", 1'b1, bt, e, 1'b1);
            if (st) return;
        end
        e = base();
        e.reg_we = ins[11:7] != 5'd0;
        e.wb_sel = ld ? 2'd1 : (jal || jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
        e.pc_we = 1'b1;
        e.pc_sel = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
        e.retire = 1'b1;
        step("wb", 1'b0, bt, e, 1'b1);
    endtask

    initial begin
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        logic [31:0] rnd;
        @(negedge clk);
        do_reset(0);
        run_instr(32'h00500093, 0, 0, 1'b0);
        run_instr(32'h00112223, 0, 3, 1'b0);
        run_instr(32'h00000463, 1, 0, 1'b1);
        run_instr(32'h00000463, 0, 0, 1'b0);
        run_instr(32'h008000EF, 2, 0, 1'b0);
        run_instr(32'h12345037, 0, 0, 1'b0);
        for (int n = 0; n < 60; n++) begin
            rnd = $urandom();
            run_instr({rnd[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
        run_instr(32'hFFFFFFFF, 0, 0, 1'b0);
        do_reset(3);
        run_instr(32'h00500093, TMO, 0, 1'b0);
        do_reset(2);
        run_instr(32'h00500093, TMO - 1, 0, 1'b0);
        run_instr(32'h00002083, 0, TMO, 1'b0);
        do_reset(4);
        instr = 32'h00500093;
        mem_ready = 1'b1;
        do_reset(3);
        run_instr(32'h0000A103, 0, TMO - 1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end
endmodule
